// File: rtl/vic_wb_buffer_pkg.sv
// Shared victim-cache / write-back buffer types and bus encodings.
// Addresses are {tag, idx, 3'b000}, so tag and set bits together span 61 bits.
package vic_wb_buffer_pkg;

  localparam int NUM_SET_BITS = 5;
  localparam int NUM_TAG_BITS = 56;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef struct packed {
    logic        valid;
    logic        dirty;
    logic [63:0] data;
  } CACHE_LINE_T;

  typedef struct packed {
    logic [NUM_TAG_BITS-1:0] tag;
    logic [NUM_SET_BITS-1:0] idx;
    CACHE_LINE_T             line;
  } VIC_CACHE_T;

  typedef struct packed {
    logic                    valid;
    logic [NUM_TAG_BITS-1:0] tag;
    logic [NUM_SET_BITS-1:0] idx;
    logic [63:0]             data;
  } WB_ENTRY_T;

  localparam WB_ENTRY_T EMPTY_WB_ENTRY = '0;

  function automatic logic [63:0] wb_addr(input WB_ENTRY_T e);
    return {e.tag, e.idx, 3'b000};
  endfunction

endpackage

// File: rtl/vic_wb_buffer_if.sv
// Eviction, lookup and memory-port signals of the write-back buffer.
// master = surrounding logic (victim cache, load path, arbiter); slave = buffer.
interface vic_wb_buffer_if
  import vic_wb_buffer_pkg::*;
#(
  parameter int WR_PORTS = 3,
  parameter int RD_PORTS = 2
) ();

  VIC_CACHE_T [WR_PORTS-1:0]                   evicted_vic;
  logic       [WR_PORTS-1:0]                   evicted_valid;
  logic       [RD_PORTS-1:0]                   rd_en;
  logic       [RD_PORTS-1:0][NUM_SET_BITS-1:0] rd_idx;
  logic       [RD_PORTS-1:0][NUM_TAG_BITS-1:0] rd_tag;
  logic       [RD_PORTS-1:0]                   rd_hit;
  logic       [RD_PORTS-1:0][63:0]             rd_data;
  logic                                        mem_grant;
  logic       [3:0]                            mem2proc_response;
  logic                                        wb_req;
  BUS_COMMAND                                  proc2mem_command;
  logic       [63:0]                           proc2mem_addr;
  logic       [63:0]                           proc2mem_data;
  logic                                        wb_stall;
  logic                                        wb_empty;

  modport master (
    output evicted_vic, evicted_valid, rd_en, rd_idx, rd_tag, mem_grant, mem2proc_response,
    input  rd_hit, rd_data, wb_req, proc2mem_command, proc2mem_addr, proc2mem_data,
           wb_stall, wb_empty
  );

  modport slave (
    input  evicted_vic, evicted_valid, rd_en, rd_idx, rd_tag, mem_grant, mem2proc_response,
    output rd_hit, rd_data, wb_req, proc2mem_command, proc2mem_addr, proc2mem_data,
           wb_stall, wb_empty
  );

endinterface

// File: rtl/vic_wb_buffer_age_select.sv
// Picks the youngest hit in a circular FIFO: the hit slot closest to the tail.
// Scans offsets from the head upward so the last hit seen is the youngest.
module vic_wb_buffer_age_select #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] hit_i,
  input  logic [PTR_W-1:0] head_i,
  output logic             any_o,
  output logic [PTR_W-1:0] sel_o
);

  logic [PTR_W-1:0] slot;

  always_comb begin
    any_o = 1'b0;
    sel_o = head_i;
    slot  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_i + PTR_W'(k);
      if (hit_i[slot]) begin
        any_o = 1'b1;
        sel_o = slot;
      end
    end
  end

endmodule

// File: rtl/vic_wb_buffer.sv
// Victim-cache write-back buffer: queues dirty evictions, drains one BUS_STORE per
// accepted grant, and answers CAM lookups for data not yet written back.
module vic_wb_buffer
  import vic_wb_buffer_pkg::*;
#(
  parameter int WR_PORTS = 3,
  parameter int RD_PORTS = 2,
  parameter int WB_DEPTH = 8
) (
  input logic           clock,
  input logic           reset,
  vic_wb_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  WB_ENTRY_T           entries_q [WB_DEPTH];
  WB_ENTRY_T           entries_d [WB_DEPTH];
  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                pop;
  logic [CNT_W-1:0]    free_slots, n_enq;
  logic [WR_PORTS-1:0] qual;
  WB_ENTRY_T           head_e;

  always_comb begin
    pop        = (count_q != '0) && bus.mem_grant && (bus.mem2proc_response != 4'h0);
    // A pop in the same cycle lets a full buffer accept one more entry.
    free_slots = CNT_W'(WB_DEPTH) - count_q + CNT_W'(pop);
    entries_d  = entries_q;
    n_enq      = '0;
    qual       = '0;
    if (pop) entries_d[head_q].valid = 1'b0;
    for (int i = 0; i < WR_PORTS; i++) begin
      qual[i] = bus.evicted_valid[i] && bus.evicted_vic[i].line.valid &&
                bus.evicted_vic[i].line.dirty;
      if (qual[i] && (n_enq < free_slots)) begin
        entries_d[tail_q + n_enq[PTR_W-1:0]] = '{valid: 1'b1,
                                                 tag:   bus.evicted_vic[i].tag,
                                                 idx:   bus.evicted_vic[i].idx,
                                                 data:  bus.evicted_vic[i].line.data};
        n_enq = n_enq + CNT_W'(1);
      end
    end
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + n_enq[PTR_W-1:0];
    count_d = count_q - CNT_W'(pop) + n_enq;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < WB_DEPTH; k++) entries_q[k] <= EMPTY_WB_ENTRY;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int k = 0; k < WB_DEPTH; k++) entries_q[k] <= entries_d[k];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef DEBUG
  always_ff @(posedge clock) begin
    if (!reset) assert (CNT_W'($countones(qual)) <= free_slots);
  end
`endif

  assign head_e               = entries_q[head_q];
  assign bus.wb_req           = (count_q != '0);
  assign bus.wb_empty         = (count_q == '0);
  assign bus.wb_stall         = (CNT_W'(WB_DEPTH) - count_q) < CNT_W'(WR_PORTS);
  assign bus.proc2mem_addr    = bus.wb_req ? wb_addr(head_e) : 64'h0;
  assign bus.proc2mem_data    = bus.wb_req ? head_e.data : 64'h0;
  assign bus.proc2mem_command = (bus.wb_req && bus.mem_grant) ? BUS_STORE : BUS_NONE;

  for (genvar r = 0; r < RD_PORTS; r++) begin : g_rd
    logic [WB_DEPTH-1:0] match;
    logic                any;
    logic [PTR_W-1:0]    sel;

    always_comb begin
      match = '0;
      for (int j = 0; j < WB_DEPTH; j++) begin
        match[j] = entries_q[j].valid && (entries_q[j].tag == bus.rd_tag[r]) &&
                   (entries_q[j].idx == bus.rd_idx[r]);
      end
    end

    vic_wb_buffer_age_select #(.DEPTH(WB_DEPTH)) u_age (
      .hit_i  (match),
      .head_i (head_q),
      .any_o  (any),
      .sel_o  (sel)
    );

    assign bus.rd_hit[r]  = bus.rd_en[r] && any;
    assign bus.rd_data[r] = bus.rd_hit[r] ? entries_q[sel].data : 64'h0;
  end

endmodule
